// File: rtl/key_loader.sv
// One-time-programmable serial key loader: shifts a key in LSB first, checks it,
// and commits it once into a hold register. Optional parity check: KEY_LOADER_PARITY_EN.
module key_loader #(
    parameter int KEY_WIDTH = 3,
    parameter int CNT_W     = $clog2(KEY_WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_start,
    input  logic                 key_sdi,
    input  logic                 key_valid,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 key_ok,
    output logic                 key_err,
    output logic                 busy
);

`ifdef KEY_LOADER_PARITY_EN
    localparam int FRAME_LEN = KEY_WIDTH + 1;
`else
    localparam int FRAME_LEN = KEY_WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic                   key_ok_q, key_ok_d;
    logic                   key_err_q, key_err_d;
    logic                   busy_q;
    logic                   frame_good;

`ifdef KEY_LOADER_PARITY_EN
    // Even parity: the key bits and the trailing parity bit XOR to zero.
    assign frame_good = ~(^sreg_q);
`else
    assign frame_good = 1'b1;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        key_ok_d  = key_ok_q;
        key_err_d = key_err_q;

        case (state_q)
            IDLE: begin
                if (key_start) begin
                    state_d   = SHIFT;
                    sreg_d    = '0;
                    cnt_d     = '0;
                    key_err_d = 1'b0;
                end
            end
            SHIFT: begin
                if (key_start) begin
                    sreg_d = '0;
                    cnt_d  = '0;
                end else if (key_valid) begin
                    for (int i = 0; i < FRAME_LEN; i++) begin
                        if (cnt_q == CNT_W'(i)) sreg_d[i] = key_sdi;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = CHECK;
                end
            end
            CHECK: begin
                if (frame_good) begin
                    key_d    = sreg_q[KEY_WIDTH-1:0];
                    key_ok_d = 1'b1;
                    state_d  = LOCKED;
                end else begin
                    key_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: state_d = IDLE;
        endcase
    end

    // busy is registered from the next state so it tracks SHIFT/CHECK with no input-to-output path.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            key_q     <= '0;
            key_ok_q  <= 1'b0;
            key_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            key_ok_q  <= key_ok_d;
            key_err_q <= key_err_d;
            busy_q    <= (state_d == SHIFT) || (state_d == CHECK);
        end
    end

    assign key     = key_q;
    assign key_ok  = key_ok_q;
    assign key_err = key_err_q;
    assign busy    = busy_q;

endmodule

// File: doc/key_loader.md
# key_loader

Upstream key-provisioning stage for the logic-locked benchmark netlists. It receives the secret key over a one-bit serial interface and optionally checks it against a parity bit. The key is then committed once into a hold register that drives the locked circuit's `key_*` inputs. Until a valid commit, the key outputs stay all-zero, so no partial key ever reaches the locked logic. After a commit the block is locked until reset, which makes it one-time-programmable per power cycle.

## Interface
- `KEY_WIDTH`, default 3 — number of key bits; must be ≥ 1.
- `CNT_W`, default `$clog2(KEY_WIDTH+2)` — width of the bit counter.

Ports:
- `clk` — input, 1 — single clock; all state updates on the rising edge.
- `rst` — input, 1 — reset; synchronous, active-high.
- `key_start` — input, 1 — one-cycle pulse that begins a load.
- `key_sdi` — input, 1 — serial key data, LSB first.
- `key_valid` — input, 1 — `key_sdi` is sampled on cycles where this is high.
- `key` — output, `KEY_WIDTH` — committed key; bit i drives `key_i` of the locked netlist.
- `key_ok` — output, 1 — high once a key is committed; stays high until reset.
- `key_err` — output, 1 — sticky; the last load failed its check.
- `busy` — output, 1 — high in SHIFT and CHECK.

## Operation
States are IDLE, SHIFT, CHECK and LOCKED.

- **Reset**
  - State goes to IDLE.
  - `key`=0, `key_ok`=0, `key_err`=0, `busy`=0.
  - Shift register and counter are cleared.
- **IDLE**
  - `key_start`=1 moves to SHIFT, clears the counter and shift register, and clears `key_err`.
  - `key_valid` in the same cycle as `key_start` is ignored.
- **SHIFT**
  - Each cycle with `key_valid`=1 shifts `key_sdi` into the register at bit position `cnt` and increments `cnt`.
  - Gaps with `key_valid`=0 are allowed and have no timeout.
  - Frame length is N = `KEY_WIDTH`+1 with parity, or `KEY_WIDTH` without it.
  - Accepting bit N-1 moves to CHECK.
  - `key_start`=1 in SHIFT restarts the load: counter and register are cleared, and `key_valid` in that cycle is ignored.
- **CHECK** (exactly one cycle)
  - With parity enabled, the received parity bit is compared with the XOR of the key bits (even parity).
  - On a match: `key` ← shift register, `key_ok` ← 1, go to LOCKED.
  - On a mismatch: `key_err` ← 1, `key` stays 0, go to IDLE.
  - Without parity the check always passes.
- **LOCKED**
  - Terminal until `rst`.
  - `key_start`, `key_valid` and `key_sdi` are ignored.
  - `key` holds its value.
- `key` changes only on the CHECK→LOCKED transition or on reset. The shift register is never visible on `key`.

## Timing
- Take the edge that accepts the final frame bit as edge E.
  - CHECK is the state for the cycle after E.
  - `key` and `key_ok` update at edge E+1 and are visible in the cycle after it.
- Best-case start-to-`key_ok` latency is N+2 edges: one for the start, N for the bits, one for CHECK.
- `busy` is registered. It rises the cycle after the accepting `key_start` and falls the same cycle `key_ok` or `key_err` rises.
- `rst` asserted in any state, including mid-SHIFT or in CHECK, takes effect at the next edge and wins over every other input.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `KEY_LOADER_PARITY_EN` defined:
  - A frame is `KEY_WIDTH` key bits followed by one even-parity bit.
  - A mismatch sets `key_err` and the block returns to IDLE, so the key can be reloaded.
- `KEY_LOADER_PARITY_EN` undefined:
  - A frame is `KEY_WIDTH` bits; CHECK always commits.
  - `key_err` is tied to 0.

## Test plan
All scenarios use `KEY_WIDTH`=3.

1. **Clean load, parity enabled.** Reset, pulse `key_start`, then send 1,0,1,0 with `key_valid` high on consecutive cycles. Expect `key`=3'b101 and `key_ok`=1 exactly 2 edges after the final bit; `key_err`=0 throughout.
2. **Parity error and retry.** Send 1,0,1,1. Expect `key_err`=1, `key`=0, `key_ok`=0 and state IDLE. A new `key_start` clears `key_err`; then send 1,1,0,0 and expect `key`=3'b011.
3. **Gapped valid and restart.** Send 1,0 with idle gaps between bits, then pulse `key_start` mid-frame with `key_valid`=1. Expect that bit dropped; then send 0,1,1,0 and expect `key`=3'b110.
4. **Lock-out.** After a successful commit of 3'b101, run a second full start+frame for 3'b010. Expect `key` to stay 3'b101, `key_ok`=1, `busy`=0.
5. **Reset mid-SHIFT.** After 2 bits, assert `rst` for 1 cycle. Expect all outputs 0 the next cycle; then a full load of 3'b111 (parity 1) commits normally.
6. **Parity disabled build.** Send 0,1,1. Expect `key`=3'b110 and `key_ok`=1 two edges after the last bit; `key_err` stays 0 for any input.
